// File: rtl/cache_bus_responder.sv
// Memory-side responder for the data-cache refill/write-back bus: 2-beat read and
// write bursts mapped onto a single-port memory with grant and 1-cycle read latency.
module cache_bus_responder #(
  parameter logic [63:0] MEM_BASE = 64'h8000_0000,
  parameter logic        WR_FIRST = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_cache_bus_r_valid,
  input  logic [63:0] io_cache_bus_r_bits_raddr,
  output logic        io_cache_bus_r_ready,
  output logic [63:0] io_cache_bus_r_bits_rdata,
  output logic        io_cache_bus_r_bits_rlast,
  input  logic        io_cache_bus_w_valid,
  input  logic [63:0] io_cache_bus_w_bits_waddr,
  input  logic [63:0] io_cache_bus_w_bits_wdata,
  input  logic        io_cache_bus_w_bits_wlast,
  output logic        io_cache_bus_w_ready,
  output logic        io_cache_bus_b_valid,
  input  logic        io_cache_bus_b_ready,
  output logic        io_mem_req,
  output logic        io_mem_we,
  output logic [63:0] io_mem_addr,
  output logic [63:0] io_mem_wdata,
  input  logic        io_mem_gnt,
  input  logic [63:0] io_mem_rdata,
  output logic [2:0]  o_dbg_state
);

  // Handshakes: a write beat fires when w_valid & w_ready; the write response completes
  // when b_valid & b_ready; a read beat is delivered whenever r_ready is high (no back-pressure);
  // a memory access is taken when io_mem_req & io_mem_gnt.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_BRESP   = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_DATA = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_next;
  logic   r_beat;
  logic   w_beat_next;
  logic   w_unused;

  assign w_unused    = ^{io_cache_bus_r_bits_raddr[3:0], io_cache_bus_w_bits_waddr[3:0]};
  assign o_dbg_state = r_state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_beat  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_beat  <= w_beat_next;
    end
  end

  always_comb begin
    w_state_next              = r_state;
    w_beat_next               = r_beat;
    io_cache_bus_r_ready      = 1'b0;
    io_cache_bus_r_bits_rdata = '0;
    io_cache_bus_r_bits_rlast = 1'b0;
    io_cache_bus_w_ready      = 1'b0;
    io_cache_bus_b_valid      = 1'b0;
    io_mem_req                = 1'b0;
    io_mem_we                 = 1'b0;
    io_mem_addr               = '0;
    io_mem_wdata              = '0;
    case (r_state)
      S_IDLE: begin
        w_beat_next = 1'b0;
        if (io_cache_bus_w_valid && (WR_FIRST || !io_cache_bus_r_valid)) begin
          w_state_next = S_WR;
        end else if (io_cache_bus_r_valid) begin
          w_state_next = S_RD_REQ;
        end
      end
      S_WR: begin
        // The memory address is only driven while a beat is actually offered.
        if (io_cache_bus_w_valid) begin
          io_mem_req           = 1'b1;
          io_mem_we            = 1'b1;
          io_mem_addr          = {io_cache_bus_w_bits_waddr[63:4], r_beat, 3'b000} - MEM_BASE;
          io_mem_wdata         = io_cache_bus_w_bits_wdata;
          io_cache_bus_w_ready = io_mem_gnt;
          if (io_mem_gnt) begin
            if (io_cache_bus_w_bits_wlast || r_beat) begin
              w_state_next = S_BRESP;
            end else begin
              w_beat_next = 1'b1;
            end
          end
        end
      end
      S_BRESP: begin
        io_cache_bus_b_valid = 1'b1;
        if (io_cache_bus_b_ready) begin
          w_state_next = S_IDLE;
        end
      end
      S_RD_REQ: begin
        io_mem_req  = 1'b1;
        io_mem_addr = {io_cache_bus_r_bits_raddr[63:4], r_beat, 3'b000} - MEM_BASE;
        if (io_mem_gnt) begin
          w_state_next = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        io_cache_bus_r_ready      = 1'b1;
        io_cache_bus_r_bits_rdata = io_mem_rdata;
        io_cache_bus_r_bits_rlast = r_beat;
        if (r_beat) begin
          w_state_next = S_IDLE;
        end else begin
          w_beat_next  = 1'b1;
          w_state_next = S_RD_REQ;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_bus_responder.sv
// Self-checking bench for cache_bus_responder: directed bursts from the test plan, then
// randomized traffic checked against a line-level memory reference model.
module tb_cache_bus_responder;

  localparam logic [63:0] BASE = 64'h8000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_cache_bus_r_valid;
  logic [63:0] io_cache_bus_r_bits_raddr;
  logic        io_cache_bus_r_ready;
  logic [63:0] io_cache_bus_r_bits_rdata;
  logic        io_cache_bus_r_bits_rlast;
  logic        io_cache_bus_w_valid;
  logic [63:0] io_cache_bus_w_bits_waddr;
  logic [63:0] io_cache_bus_w_bits_wdata;
  logic        io_cache_bus_w_bits_wlast;
  logic        io_cache_bus_w_ready;
  logic        io_cache_bus_b_valid;
  logic        io_cache_bus_b_ready;
  logic        io_mem_req;
  logic        io_mem_we;
  logic [63:0] io_mem_addr;
  logic [63:0] io_mem_wdata;
  logic        io_mem_gnt;
  logic [63:0] io_mem_rdata;
  logic [2:0]  o_dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int b_hs_cyc;
  int first_rd_cyc;
  bit gnt_rand;

  // Memory behind the responder, plus a backdoor used only for preloading.
  logic [63:0] sram [0:1023];
  logic        bd_we;
  logic [9:0]  bd_idx;
  logic [63:0] bd_data;
  // Reference model: what every 8-byte word of the window should hold.
  logic [63:0] ref_mem [0:1023];

  always #5 clock = ~clock;

  cache_bus_responder #(.MEM_BASE(BASE), .WR_FIRST(1'b1)) dut (
    .clock(clock), .reset(reset),
    .io_cache_bus_r_valid(io_cache_bus_r_valid),
    .io_cache_bus_r_bits_raddr(io_cache_bus_r_bits_raddr),
    .io_cache_bus_r_ready(io_cache_bus_r_ready),
    .io_cache_bus_r_bits_rdata(io_cache_bus_r_bits_rdata),
    .io_cache_bus_r_bits_rlast(io_cache_bus_r_bits_rlast),
    .io_cache_bus_w_valid(io_cache_bus_w_valid),
    .io_cache_bus_w_bits_waddr(io_cache_bus_w_bits_waddr),
    .io_cache_bus_w_bits_wdata(io_cache_bus_w_bits_wdata),
    .io_cache_bus_w_bits_wlast(io_cache_bus_w_bits_wlast),
    .io_cache_bus_w_ready(io_cache_bus_w_ready),
    .io_cache_bus_b_valid(io_cache_bus_b_valid),
    .io_cache_bus_b_ready(io_cache_bus_b_ready),
    .io_mem_req(io_mem_req), .io_mem_we(io_mem_we),
    .io_mem_addr(io_mem_addr), .io_mem_wdata(io_mem_wdata),
    .io_mem_gnt(io_mem_gnt), .io_mem_rdata(io_mem_rdata),
    .o_dbg_state(o_dbg_state)
  );

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (bd_we) begin
      sram[bd_idx] <= bd_data;
    end else if (io_mem_req && io_mem_gnt) begin
      if (io_mem_we) sram[io_mem_addr[12:3]] <= io_mem_wdata;
      else           io_mem_rdata <= sram[io_mem_addr[12:3]];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] word_off(input logic [63:0] addr, input int beat);
    return (addr & ~64'hF) + 64'(beat * 8) - BASE;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
    if (gnt_rand) io_mem_gnt = ($urandom_range(0, 3) != 0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_r_ready"}, 64'(io_cache_bus_r_ready), 64'd0);
    check({tag, "_rdata"}, io_cache_bus_r_bits_rdata, 64'd0);
    check({tag, "_rlast"}, 64'(io_cache_bus_r_bits_rlast), 64'd0);
    check({tag, "_w_ready"}, 64'(io_cache_bus_w_ready), 64'd0);
    check({tag, "_b_valid"}, 64'(io_cache_bus_b_valid), 64'd0);
    check({tag, "_mem_req"}, 64'(io_mem_req), 64'd0);
    check({tag, "_mem_we"}, 64'(io_mem_we), 64'd0);
    check({tag, "_mem_addr"}, io_mem_addr, 64'd0);
    check({tag, "_mem_wdata"}, io_mem_wdata, 64'd0);
    check({tag, "_state"}, 64'(o_dbg_state), 64'd0);
  endtask

  // Read burst; exp_t0/exp_t1 are the expected cycle offsets of the two data beats (-1: unchecked).
  task automatic do_read(input logic [63:0] addr, input int stall, input int exp_t0,
                         input int exp_t1, input bit drop);
    int beat;
    int stall_left;
    logic [63:0] exp_a;
    beat = 0;
    stall_left = stall;
    tick();
    io_cache_bus_r_valid = 1'b1;
    io_cache_bus_r_bits_raddr = addr;
    for (int i = 0; i < 200 && beat < 2; i++) begin
      @(negedge clock);
      exp_a = word_off(addr, beat);
      if (io_mem_req && !io_mem_we) begin
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        check("rd_addr", io_mem_addr, exp_a);
      end
      if (io_cache_bus_r_ready) begin
        check("rd_data", io_cache_bus_r_bits_rdata, ref_mem[exp_a[12:3]]);
        check("rd_rlast", 64'(io_cache_bus_r_bits_rlast), 64'(beat));
        if (beat == 0 && exp_t0 >= 0) check("rd_t0", 64'(i), 64'(exp_t0));
        if (beat == 1 && exp_t1 >= 0) check("rd_t1", 64'(i), 64'(exp_t1));
        beat++;
      end
      tick();
      if (beat == 1 && stall_left > 0) begin
        io_mem_gnt = 1'b0;
        stall_left--;
      end else if (!gnt_rand) begin
        io_mem_gnt = 1'b1;
      end
      if (drop && beat == 1) io_cache_bus_r_valid = 1'b0;
    end
    check("rd_beats", 64'(beat), 64'd2);
    io_cache_bus_r_valid = 1'b0;
  endtask

  task automatic do_write(input logic [63:0] addr, input logic [63:0] d0, input logic [63:0] d1,
                          input bit wl1, input int gap, input int b_delay);
    int beat;
    int gap_left;
    int bcnt;
    int k;
    bit done;
    logic [63:0] exp_a;
    beat = 0;
    gap_left = gap;
    tick();
    io_cache_bus_w_valid = 1'b1;
    io_cache_bus_w_bits_waddr = addr;
    io_cache_bus_w_bits_wdata = d0;
    io_cache_bus_w_bits_wlast = 1'b0;
    io_cache_bus_b_ready = (b_delay == 0);
    for (int i = 0; i < 200 && beat < 2; i++) begin
      @(negedge clock);
      if (io_cache_bus_w_ready) begin
        exp_a = word_off(addr, beat);
        check("wr_addr", io_mem_addr, exp_a);
        check("wr_we", 64'(io_mem_we), 64'd1);
        check("wr_data", io_mem_wdata, (beat == 0) ? d0 : d1);
        ref_mem[exp_a[12:3]] = (beat == 0) ? d0 : d1;
        beat++;
      end
      tick();
      if (beat == 1) begin
        if (gap_left > 0) begin
          io_cache_bus_w_valid = 1'b0;
          gap_left--;
        end else begin
          io_cache_bus_w_valid = 1'b1;
          io_cache_bus_w_bits_wdata = d1;
          io_cache_bus_w_bits_wlast = wl1;
        end
      end else if (beat == 2) begin
        io_cache_bus_w_valid = 1'b0;
        io_cache_bus_w_bits_wlast = 1'b0;
      end
    end
    check("wr_beats", 64'(beat), 64'd2);
    bcnt = 0;
    k = 0;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clock);
      if (i == 0) check("b_rise", 64'(io_cache_bus_b_valid), 64'd1);
      if (io_cache_bus_b_valid) bcnt++;
      if (io_cache_bus_b_valid && io_cache_bus_b_ready) begin
        done = 1'b1;
        b_hs_cyc = cyc;
      end
      tick();
      k++;
      if (k >= b_delay) io_cache_bus_b_ready = 1'b1;
    end
    check("b_len", 64'(bcnt), 64'(b_delay + 1));
    io_cache_bus_b_ready = 1'b0;
    @(negedge clock);
    check("b_clear", 64'(io_cache_bus_b_valid), 64'd0);
  endtask

  initial begin
    logic [63:0] a0, a1;
    bit got;
    int kind;
    reset = 1'b1;
    io_cache_bus_r_valid = 1'b0;
    io_cache_bus_r_bits_raddr = '0;
    io_cache_bus_w_valid = 1'b0;
    io_cache_bus_w_bits_waddr = '0;
    io_cache_bus_w_bits_wdata = '0;
    io_cache_bus_w_bits_wlast = 1'b0;
    io_cache_bus_b_ready = 1'b0;
    io_mem_gnt = 1'b1;
    gnt_rand = 1'b0;
    bd_we = 1'b0;
    bd_idx = '0;
    bd_data = '0;
    b_hs_cyc = 0;
    first_rd_cyc = -1;

    @(negedge clock);
    check_quiet("reset");
    for (int a = 0; a < 1024; a++) begin
      bd_we = 1'b1;
      bd_idx = 10'(a);
      if (a == 8)      bd_data = 64'h1111;
      else if (a == 9) bd_data = 64'h2222;
      else             bd_data = {$urandom, $urandom};
      ref_mem[a] = bd_data;
      @(posedge clock);
      #1;
    end
    bd_we = 1'b0;
    reset = 1'b0;

    // Basic read at T: beats at T+2 and T+4, addresses 0x40/0x48.
    do_read(BASE + 64'h40, 0, 2, 4, 1'b0);
    // Basic write with b_ready held high.
    do_write(BASE + 64'h80, 64'hAAAA, 64'hBBBB, 1'b1, 0, 0);
    check("sram_80", sram[16], 64'hAAAA);
    check("sram_88", sram[17], 64'hBBBB);
    do_read(BASE + 64'h80, 0, 2, 4, 1'b0);

    // Simultaneous write and read: write wins and completes first.
    first_rd_cyc = -1;
    fork
      do_write(BASE + 64'h100, 64'hC0C0_0001, 64'hC0C0_0002, 1'b1, 0, 0);
      do_read(BASE + 64'h200, 0, -1, -1, 1'b0);
    join
    check("order_wr_rd", 64'(first_rd_cyc > b_hs_cyc), 64'd1);
    check("sram_100", sram[32], 64'hC0C0_0001);

    // Grant stall of 3 cycles on read beat 1.
    do_read(BASE + 64'h200, 3, 2, 7, 1'b0);

    // b_ready withheld for 5 cycles with a read waiting.
    first_rd_cyc = -1;
    fork
      do_write(BASE + 64'h300, 64'hD00D_0001, 64'hD00D_0002, 1'b0, 1, 5);
      do_read(BASE + 64'h308, 0, -1, -1, 1'b0);
    join
    check("order_bdelay", 64'(first_rd_cyc > b_hs_cyc), 64'd1);

    // Reset in RD_DATA beat 0: outputs clear in the same cycle.
    tick();
    io_cache_bus_r_valid = 1'b1;
    io_cache_bus_r_bits_raddr = BASE + 64'h40;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      if (io_cache_bus_r_ready) got = 1'b1;
    end
    check("rst_reach_rd_data", 64'(got), 64'd1);
    reset = 1'b1;
    #1;
    check_quiet("async_rst");
    tick();
    io_cache_bus_r_valid = 1'b0;
    tick();
    reset = 1'b0;
    @(negedge clock);
    check_quiet("post_rst");
    do_read(BASE + 64'h50, 0, 2, 4, 1'b0);

    // Randomized traffic with random grant.
    gnt_rand = 1'b1;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 2);
      a0 = BASE + 64'($urandom_range(0, 511)) * 16 + 64'($urandom_range(0, 15));
      a1 = BASE + 64'($urandom_range(0, 511)) * 16 + 64'($urandom_range(0, 15));
      if (kind == 0) begin
        do_read(a0, 0, -1, -1, 1'($urandom_range(0, 1)));
      end else if (kind == 1) begin
        do_write(a0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 2), $urandom_range(0, 3));
      end else begin
        first_rd_cyc = -1;
        fork
          do_write(a0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1,
                   $urandom_range(0, 1), $urandom_range(0, 3));
          do_read(a1, 0, -1, -1, 1'b0);
        join
        check("order_rand", 64'(first_rd_cyc > b_hs_cyc), 64'd1);
      end
    end
    gnt_rand = 1'b0;
    io_mem_gnt = 1'b1;
    tick();
    check("final_sram_80", sram[16], ref_mem[16]);
    check("final_sram_100", sram[32], ref_mem[32]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
